// File: rtl/ay_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ay_bus_sequencer
// Brief    : Turns CPU port requests into timed BDIR/BC1 strobes for two
//            YM2149 cores and runs the R7 mute engine between them.
// Revision : 1.0 - initial release
// ============================================================================
module ay_bus_sequencer #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       en_ts,
    input  logic       cpu_req,
    input  logic [1:0] cpu_op,
    input  logic       cpu_sel,
    input  logic [7:0] cpu_d,
    input  logic       mute,
    output logic       ay_bdir,
    output logic       ay_bc1,
    output logic       ay_sel,
    output logic [7:0] ay_di,
    output logic       rd_capture,
    output logic       busy,
    output logic       mute_active
);

    localparam logic [1:0] C_OP_ADDR  = 2'b00;
    localparam logic [1:0] C_OP_WR    = 2'b01;
    localparam logic [1:0] C_OP_RD    = 2'b10;
    localparam logic [1:0] C_OP_NONE  = 2'b11;
    localparam logic [2:0] C_CNT_LAST = 3'(STROBE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_cnt;
    logic       r_bdir;
    logic       r_bc1;
    logic       r_sel;
    logic [7:0] r_di;
    logic       r_rdcap;
    logic       r_cur_rd;
    logic       r_mute_active;

    logic       r_pend_vld;
    logic [1:0] r_pend_op;
    logic       r_pend_sel;
    logic [7:0] r_pend_d;

    logic [3:0] r_addr [2];
    logic [7:0] r_r7   [2];

    logic       r_eng_run;
    logic       r_eng_tgt;
    logic       r_eng_chip;
    logic       r_eng_last;
    logic [1:0] r_eng_step;

    logic       w_in_vld;
    logic       w_cpu_vld;
    logic [1:0] w_cpu_op;
    logic       w_cpu_sel;
    logic [7:0] w_cpu_d;
    logic       w_disp_pt;
    logic       w_eng_cont;
    logic       w_eng_mid;
    logic       w_eng_start;
    logic       w_iss_cpu;
    logic       w_iss_eng;
    logic [1:0] w_eng_op;
    logic [7:0] w_eng_d;
    logic [1:0] w_iss_op;
    logic       w_iss_sel;
    logic [7:0] w_iss_d;

    // A live request bypasses the pending slot so an idle bus strobes on the next cycle.
    assign w_in_vld  = cpu_req && (cpu_op != C_OP_NONE);
    assign w_cpu_vld = w_in_vld || r_pend_vld;
    assign w_cpu_op  = w_in_vld ? cpu_op  : r_pend_op;
    assign w_cpu_sel = w_in_vld ? cpu_sel : r_pend_sel;
    assign w_cpu_d   = w_in_vld ? cpu_d   : r_pend_d;

    assign w_disp_pt   = (r_state == S_IDLE) || (r_state == S_GAP);
    assign w_eng_cont  = r_eng_run && !r_eng_last;
    assign w_eng_mid   = w_eng_cont && (r_eng_step != 2'd0);
    assign w_eng_start = (r_state == S_IDLE) && !r_eng_run && (mute != r_mute_active);

    assign w_iss_cpu = w_disp_pt && !w_eng_mid && w_cpu_vld;
    assign w_iss_eng = w_disp_pt && (w_eng_mid || (!w_cpu_vld && (w_eng_cont || w_eng_start)));

    always_comb begin
        w_eng_op = C_OP_ADDR;
        w_eng_d  = 8'h07;
        case (r_eng_step)
            2'd0: begin
                w_eng_op = C_OP_ADDR;
                w_eng_d  = 8'h07;
            end
            2'd1: begin
                w_eng_op = C_OP_WR;
                w_eng_d  = r_eng_tgt ? (r_r7[r_eng_chip] | 8'h3F) : r_r7[r_eng_chip];
            end
            default: begin
                w_eng_op = C_OP_ADDR;
                w_eng_d  = {4'h0, r_addr[r_eng_chip]};
            end
        endcase
    end

    always_comb begin
        w_iss_op  = w_eng_op;
        w_iss_sel = r_eng_chip;
        w_iss_d   = w_eng_d;
        if (w_iss_cpu) begin
            w_iss_op  = w_cpu_op;
            w_iss_sel = w_cpu_sel;
            w_iss_d   = w_cpu_d;
            if ((w_cpu_op == C_OP_WR) && r_mute_active && (r_addr[w_cpu_sel] == 4'h7)) begin
                w_iss_d = w_cpu_d | 8'h3F;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 3'd0;
            r_bdir        <= 1'b0;
            r_bc1         <= 1'b0;
            r_sel         <= 1'b0;
            r_di          <= 8'h00;
            r_rdcap       <= 1'b0;
            r_cur_rd      <= 1'b0;
            r_mute_active <= 1'b0;
            r_pend_vld    <= 1'b0;
            r_pend_op     <= 2'b00;
            r_pend_sel    <= 1'b0;
            r_pend_d      <= 8'h00;
            r_eng_run     <= 1'b0;
            r_eng_tgt     <= 1'b0;
            r_eng_chip    <= 1'b0;
            r_eng_last    <= 1'b0;
            r_eng_step    <= 2'd0;
        end else begin
            if (w_iss_cpu) begin
                r_pend_vld <= 1'b0;
            end else if (w_in_vld) begin
                r_pend_vld <= 1'b1;
                r_pend_op  <= cpu_op;
                r_pend_sel <= cpu_sel;
                r_pend_d   <= cpu_d;
            end

            case (r_state)
                S_IDLE, S_GAP: begin
                    r_state <= S_IDLE;
                    r_bdir  <= 1'b0;
                    r_bc1   <= 1'b0;
                    r_rdcap <= 1'b0;
                    if ((r_state == S_GAP) && r_eng_last) begin
                        r_eng_run     <= 1'b0;
                        r_eng_last    <= 1'b0;
                        r_eng_chip    <= 1'b0;
                        r_mute_active <= r_eng_tgt;
                    end
                    if (w_iss_cpu || w_iss_eng) begin
                        r_state  <= S_STROBE;
                        r_cnt    <= 3'd0;
                        r_bdir   <= (w_iss_op != C_OP_RD);
                        r_bc1    <= (w_iss_op != C_OP_WR);
                        r_sel    <= w_iss_sel;
                        r_di     <= w_iss_d;
                        r_cur_rd <= w_iss_cpu && (w_iss_op == C_OP_RD);
                        r_rdcap  <= w_iss_cpu && (w_iss_op == C_OP_RD) && (C_CNT_LAST == 3'd0);
                    end
                    if (w_iss_eng) begin
                        if (w_eng_start) begin
                            r_eng_run <= 1'b1;
                            r_eng_tgt <= mute;
                        end
                        case (r_eng_step)
                            2'd0:    r_eng_step <= 2'd1;
                            2'd1:    r_eng_step <= 2'd2;
                            default: begin
                                r_eng_step <= 2'd0;
                                if (!r_eng_chip && en_ts) begin
                                    r_eng_chip <= 1'b1;
                                end else begin
                                    r_eng_last <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                S_STROBE: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_state <= S_GAP;
                        r_bdir  <= 1'b0;
                        r_bc1   <= 1'b0;
                        r_rdcap <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_rdcap <= r_cur_rd && ((r_cnt + 3'd1) == C_CNT_LAST);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_bdir  <= 1'b0;
                    r_bc1   <= 1'b0;
                    r_rdcap <= 1'b0;
                end
            endcase
        end
    end

    // Shadows track CPU traffic only; engine strobes leave them untouched.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_addr[0] <= 4'h0;
            r_addr[1] <= 4'h0;
            r_r7[0]   <= 8'h00;
            r_r7[1]   <= 8'h00;
        end else begin
            if (w_iss_cpu) begin
                if ((w_cpu_op == C_OP_ADDR) && (w_cpu_d[7:4] == 4'h0)) begin
                    r_addr[w_cpu_sel] <= w_cpu_d[3:0];
                end
                if ((w_cpu_op == C_OP_WR) && (r_addr[w_cpu_sel] == 4'h7)) begin
                    r_r7[w_cpu_sel] <= w_cpu_d;
                end
            end
            if (!en_ts) begin
                r_addr[1] <= 4'h0;
                r_r7[1]   <= 8'h00;
            end
        end
    end

    assign ay_bdir     = r_bdir;
    assign ay_bc1      = r_bc1;
    assign ay_sel      = r_sel;
    assign ay_di       = r_di;
    assign rd_capture  = r_rdcap;
    assign mute_active = r_mute_active;
    assign busy        = (r_state != S_IDLE) || r_pend_vld;

endmodule
`default_nettype wire

// File: tb/tb_ay_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ay_bus_sequencer
// Brief    : Directed bench for ay_bus_sequencer at STROBE_CYCLES = 2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ay_bus_sequencer;

    localparam int STB = 2;

    logic       clk28 = 1'b0;
    logic       rst_n;
    logic       en_ts;
    logic       cpu_req;
    logic [1:0] cpu_op;
    logic       cpu_sel;
    logic [7:0] cpu_d;
    logic       mute;
    logic       ay_bdir;
    logic       ay_bc1;
    logic       ay_sel;
    logic [7:0] ay_di;
    logic       rd_capture;
    logic       busy;
    logic       mute_active;

    int n_cmp = 0;
    int n_err = 0;

    ay_bus_sequencer #(.STROBE_CYCLES(STB)) u_dut (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .en_ts       (en_ts),
        .cpu_req     (cpu_req),
        .cpu_op      (cpu_op),
        .cpu_sel     (cpu_sel),
        .cpu_d       (cpu_d),
        .mute        (mute),
        .ay_bdir     (ay_bdir),
        .ay_bc1      (ay_bc1),
        .ay_sel      (ay_sel),
        .ay_di       (ay_di),
        .rd_capture  (rd_capture),
        .busy        (busy),
        .mute_active (mute_active)
    );

    always #5 clk28 = ~clk28;

    task automatic step();
        @(posedge clk28);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu(input logic [1:0] op, input logic s, input logic [7:0] d);
        cpu_req = 1'b1;
        cpu_op  = op;
        cpu_sel = s;
        cpu_d   = d;
        step();
        cpu_req = 1'b0;
    endtask

    // Checks {bdir,bc1,sel,rd_capture,di} over a whole strobe, then the gap cycle.
    task automatic exp_strobe(input string tag, input logic b, input logic c,
                              input logic s, input logic [7:0] d, input logic rd);
        for (int i = 0; i < STB; i++) begin
            chk(tag, 32'({ay_bdir, ay_bc1, ay_sel, rd_capture, ay_di}),
                     32'({b, c, s, (rd && (i == STB - 1)), d}));
            step();
        end
        chk({tag, "_gap"}, 32'({ay_bdir, ay_bc1, rd_capture}), 32'(3'b000));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        en_ts   = 1'b1;
        cpu_req = 1'b0;
        cpu_op  = 2'b00;
        cpu_sel = 1'b0;
        cpu_d   = 8'h00;
        mute    = 1'b0;
        repeat (3) step();
        chk("reset_outs", 32'({ay_bdir, ay_bc1, ay_sel, ay_di, rd_capture, busy, mute_active}), 32'd0);
        rst_n = 1'b1;
        step();

        // address 07 then data B8 to chip 0
        cpu(2'b00, 1'b0, 8'h07);
        exp_strobe("addr07", 1'b1, 1'b1, 1'b0, 8'h07, 1'b0);
        chk("busy_gap", 32'(busy), 32'd1);
        step();
        chk("busy_idle", 32'(busy), 32'd0);
        cpu(2'b01, 1'b0, 8'hB8);
        exp_strobe("wrB8", 1'b1, 1'b0, 1'b0, 8'hB8, 1'b0);
        step();

        // address shadows 3 / 9
        cpu(2'b00, 1'b0, 8'h03);
        exp_strobe("addr03", 1'b1, 1'b1, 1'b0, 8'h03, 1'b0);
        step();
        cpu(2'b00, 1'b1, 8'h09);
        exp_strobe("addr09", 1'b1, 1'b1, 1'b1, 8'h09, 1'b0);
        step();

        // mute rise: six engine strobes
        mute = 1'b1;
        step();
        exp_strobe("m0_a7", 1'b1, 1'b1, 1'b0, 8'h07, 1'b0); step();
        exp_strobe("m0_d",  1'b1, 1'b0, 1'b0, 8'hBF, 1'b0); step();
        exp_strobe("m0_r",  1'b1, 1'b1, 1'b0, 8'h03, 1'b0); step();
        exp_strobe("m1_a7", 1'b1, 1'b1, 1'b1, 8'h07, 1'b0); step();
        exp_strobe("m1_d",  1'b1, 1'b0, 1'b1, 8'h3F, 1'b0); step();
        exp_strobe("m1_r",  1'b1, 1'b1, 1'b1, 8'h09, 1'b0);
        chk("mact_lastgap", 32'(mute_active), 32'd0);
        step();
        chk("mact_rise", 32'({mute_active, busy}), 32'(2'b10));

        // muted R7 write is forced
        cpu(2'b00, 1'b0, 8'h07);
        exp_strobe("addr07b", 1'b1, 1'b1, 1'b0, 8'h07, 1'b0);
        step();
        cpu(2'b01, 1'b0, 8'h80);
        exp_strobe("wr80_forced", 1'b1, 1'b0, 1'b0, 8'hBF, 1'b0);
        step();

        // read strobe
        cpu(2'b10, 1'b0, 8'h00);
        exp_strobe("read", 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        step();

        // unmute with a CPU write landing in chip 0's group
        mute = 1'b0;
        step();
        chk("u0_a7_c1", 32'({ay_bdir, ay_bc1, ay_sel, ay_di}), 32'({3'b110, 8'h07}));
        step();
        chk("u0_a7_c2", 32'({ay_bdir, ay_bc1, ay_sel, ay_di}), 32'({3'b110, 8'h07}));
        cpu(2'b01, 1'b0, 8'h55);
        chk("u0_a7_gap", 32'({ay_bdir, ay_bc1, busy}), 32'(3'b001));
        step();
        exp_strobe("u0_d",  1'b1, 1'b0, 1'b0, 8'h80, 1'b0); step();
        exp_strobe("u0_r",  1'b1, 1'b1, 1'b0, 8'h07, 1'b0); step();
        exp_strobe("cpu55", 1'b1, 1'b0, 1'b0, 8'h7F, 1'b0); step();
        exp_strobe("u1_a7", 1'b1, 1'b1, 1'b1, 8'h07, 1'b0); step();
        exp_strobe("u1_d",  1'b1, 1'b0, 1'b1, 8'h00, 1'b0); step();
        exp_strobe("u1_r",  1'b1, 1'b1, 1'b1, 8'h09, 1'b0);
        step();
        chk("mact_fall", 32'({mute_active, busy}), 32'(2'b00));

        // op 11 is dropped
        cpu(2'b11, 1'b0, 8'hAA);
        chk("op11_drop", 32'({ay_bdir, ay_bc1, busy}), 32'(3'b000));

        // high-nibble address strobes but keeps shadow
        cpu(2'b00, 1'b0, 8'h17);
        exp_strobe("addr17", 1'b1, 1'b1, 1'b0, 8'h17, 1'b0);
        step();

        // reset during the engine data strobe
        mute = 1'b1;
        step();
        exp_strobe("r0_a7", 1'b1, 1'b1, 1'b0, 8'h07, 1'b0);
        step();
        chk("r0_d_c1", 32'({ay_bdir, ay_bc1, ay_sel, ay_di}), 32'({3'b100, 8'h7F}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'({ay_bdir, ay_bc1, ay_sel, ay_di, rd_capture, busy, mute_active}), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        chk("rst_mact", 32'(mute_active), 32'd0);
        step();
        exp_strobe("p0_a7", 1'b1, 1'b1, 1'b0, 8'h07, 1'b0); step();
        exp_strobe("p0_d",  1'b1, 1'b0, 1'b0, 8'h3F, 1'b0); step();
        exp_strobe("p0_r",  1'b1, 1'b1, 1'b0, 8'h00, 1'b0); step();
        exp_strobe("p1_a7", 1'b1, 1'b1, 1'b1, 8'h07, 1'b0); step();
        exp_strobe("p1_d",  1'b1, 1'b0, 1'b1, 8'h3F, 1'b0); step();
        exp_strobe("p1_r",  1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        step();
        chk("rerun_mact", 32'(mute_active), 32'd1);

        // single-chip unmute skips chip 1
        en_ts = 1'b0;
        mute  = 1'b0;
        step();
        exp_strobe("s0_a7", 1'b1, 1'b1, 1'b0, 8'h07, 1'b0); step();
        exp_strobe("s0_d",  1'b1, 1'b0, 1'b0, 8'h00, 1'b0); step();
        exp_strobe("s0_r",  1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        step();
        chk("single_end", 32'({ay_bdir, ay_bc1, mute_active, busy}), 32'(4'b0000));
        step();
        chk("single_quiet", 32'({ay_bdir, ay_bc1, busy}), 32'(3'b000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
